// File: rtl/pwd_control_pkg.sv
// Shared types and parameter checks for the pwd_control breathing-LED driver.
//   dir_e     : ramp direction (UP = 0, DOWN = 1)
//   paramsOk  : elaboration-time check of COUNTER_WIDTH / MAX_COUNT / DUTY_STEP
//   rampPeriods : number of PWM periods in one full 0 -> max -> 0 breath
package pwd_control_pkg;

  // Ramp direction of the duty value.
  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_e;

  // True when the counter can hold MAX_COUNT and the step is in 1..MAX_COUNT.
  function automatic bit paramsOk(input int unsigned counterWidth,
                                  input int unsigned maxCount,
                                  input int unsigned dutyStep);
    longint unsigned limit;
    limit = 64'd1 << counterWidth;
    return (counterWidth >= 1) && (counterWidth < 32) &&
           (maxCount >= 1) && (64'(maxCount) < limit) &&
           (dutyStep >= 1) && (dutyStep <= maxCount);
  endfunction

  // Periods in a full breath: up ceil(max/step) periods, then down as many.
  function automatic int unsigned rampPeriods(input int unsigned maxCount,
                                              input int unsigned dutyStep);
    return 2 * ((maxCount + dutyStep - 1) / dutyStep);
  endfunction

endpackage

// File: rtl/pwd_control_if.sv
// LED output bundle of pwd_control.
//   pwd_out : registered PWM level driven toward the LED pin
//   master  : the driver side (pwd_control)
//   slave   : the consumer side (board top / testbench)
interface pwd_control_if;

  logic pwd_out;

  modport master (output pwd_out);
  modport slave  (input  pwd_out);

endinterface

// File: rtl/pwd_control_pwm_core.sv
// PWM core: free-running period counter, duty comparator and output register.
//   clk_in         : clock, rising edge
//   rst_n_in       : synchronous active-low reset
//   duty           : high cycles per period (0..MAX_COUNT)
//   endOfPeriod_c  : combinational, high in the last cycle of the period
//   pwm            : registered (cnt < duty)
module pwm_core #(
  parameter int unsigned COUNTER_WIDTH = 8,
  parameter int unsigned MAX_COUNT     = 200
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic [COUNTER_WIDTH-1:0] duty,
  output logic                     endOfPeriod_c,
  output logic                     pwm
);

  localparam logic [COUNTER_WIDTH-1:0] LAST_CNT = COUNTER_WIDTH'(MAX_COUNT - 1);
  localparam logic [COUNTER_WIDTH-1:0] ONE      = COUNTER_WIDTH'(1);

  logic [COUNTER_WIDTH-1:0] cnt;

  // Wrap cycle; the ramp FSM updates duty on this same edge.
  assign endOfPeriod_c = (cnt == LAST_CNT);

  // Counter and compare register; the compare of cnt = k shows one edge later.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      cnt <= '0;
      pwm <= 1'b0;
    end else begin
      cnt <= endOfPeriod_c ? '0 : cnt + ONE;
      pwm <= (cnt < duty);
    end
  end

endmodule

// File: rtl/pwd_control.sv
// Breathing LED driver: ramps a PWM duty value 0 -> MAX_COUNT -> 0, one step
// per PWM period, and drives the resulting PWM level on bus.pwd_out.
//   clk_in   : clock, rising edge
//   rst_n_in : synchronous active-low reset
//   bus      : pwd_control_if master, carries the registered pwd_out
module pwd_control
  import pwd_control_pkg::*;
#(
  parameter int unsigned COUNTER_WIDTH = 8,
  parameter int unsigned MAX_COUNT     = 200,
  parameter int unsigned DUTY_STEP     = 1
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  pwd_control_if.master bus
);

  // One extra bit so duty + step can never wrap before the saturation test.
  localparam int unsigned SUM_W = COUNTER_WIDTH + 1;

  localparam logic [SUM_W-1:0]         STEP_W = SUM_W'(DUTY_STEP);
  localparam logic [SUM_W-1:0]         MAX_W  = SUM_W'(MAX_COUNT);
  localparam logic [COUNTER_WIDTH-1:0] STEP_N = COUNTER_WIDTH'(DUTY_STEP);
  localparam logic [COUNTER_WIDTH-1:0] MAX_N  = COUNTER_WIDTH'(MAX_COUNT);

  generate
    if (!paramsOk(COUNTER_WIDTH, MAX_COUNT, DUTY_STEP)) begin : gParamCheck
      $error("pwd_control: need MAX_COUNT < 2**COUNTER_WIDTH and 1 <= DUTY_STEP <= MAX_COUNT");
    end
  endgenerate

  dir_e                     dir;
  dir_e                     dirNext;
  logic [COUNTER_WIDTH-1:0] duty;
  logic [COUNTER_WIDTH-1:0] dutyNext;
  logic [SUM_W-1:0]         dutyUp_c;
  logic                     endOfPeriod_c;
  logic                     pwm;

  pwm_core #(
    .COUNTER_WIDTH (COUNTER_WIDTH),
    .MAX_COUNT     (MAX_COUNT)
  ) uCore (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .duty          (duty),
    .endOfPeriod_c (endOfPeriod_c),
    .pwm           (pwm)
  );

  assign dutyUp_c = {1'b0, duty} + STEP_W;

  // Ramp state register; reset wins even on a period-end edge.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      dir  <= UP;
      duty <= '0;
    end else begin
      dir  <= dirNext;
      duty <= dutyNext;
    end
  end

  // Ramp next-state: saturate and turn around in the same update so the
  // extremes last exactly one period.
  always_comb begin
    dirNext  = dir;
    dutyNext = duty;
    if (endOfPeriod_c) begin
      case (dir)
        UP: begin
          if (dutyUp_c >= MAX_W) begin
            dutyNext = MAX_N;
            dirNext  = DOWN;
          end else begin
            dutyNext = dutyUp_c[COUNTER_WIDTH-1:0];
          end
        end
        DOWN: begin
          if ({1'b0, duty} <= STEP_W) begin
            dutyNext = '0;
            dirNext  = UP;
          end else begin
            dutyNext = duty - STEP_N;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.pwd_out = pwm;

endmodule

// File: tb/tb_pwd_control.sv
// Self-checking bench for pwd_control: three instances with different ramp
// parameters share one clock; a scoreboard queue holds the expected pwd_out
// per cycle, built from the required duty sequences.
module tb_pwd_control;
  import pwd_control_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstA = 1'b0;
  logic rstB = 1'b0;
  logic rstC = 1'b0;

  pwd_control_if busA ();
  pwd_control_if busB ();
  pwd_control_if busC ();

  pwd_control #(.COUNTER_WIDTH(8), .MAX_COUNT(4),  .DUTY_STEP(1))
    dutA (.clk_in(clk), .rst_n_in(rstA), .bus(busA));
  pwd_control #(.COUNTER_WIDTH(8), .MAX_COUNT(10), .DUTY_STEP(4))
    dutB (.clk_in(clk), .rst_n_in(rstB), .bus(busB));
  pwd_control dutC (.clk_in(clk), .rst_n_in(rstC), .bus(busC));

  int errors = 0;
  int checks = 0;
  bit expQ[$];

  // Expected outputs of one period: the first d cycles high, the rest low.
  function automatic void pushPeriod(input int maxc, input int d, input int cycles);
    for (int k = 0; k < cycles; k++) expQ.push_back(k < d);
  endfunction

  task automatic test_reset();
    rstA = 1'b0;
    repeat (5) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (busA.pwd_out !== 1'b0) begin
        errors++; $display("FAIL reset_pwd: got %b want 0", busA.pwd_out);
      end
      checks++;
      if (dutA.uCore.cnt !== 8'd0) begin
        errors++; $display("FAIL reset_cnt: got %0d want 0", dutA.uCore.cnt);
      end
      checks++;
      if (dutA.duty !== 8'd0) begin
        errors++; $display("FAIL reset_duty: got %0d want 0", dutA.duty);
      end
    end
    rstA = 1'b1;
  endtask

  // Ten periods from release, first period must stay fully low.
  task automatic test_ramp();
    int seq[10] = '{0, 1, 2, 3, 4, 3, 2, 1, 0, 1};
    for (int p = 0; p < 10; p++) begin
      int high = 0;
      pushPeriod(4, seq[p], 4);
      for (int k = 0; k < 4; k++) begin
        bit exp;
        @(posedge clk); @(negedge clk);
        if (k == 0) begin
          checks++;
          if (dutA.duty !== 8'(seq[p])) begin
            errors++; $display("FAIL ramp_duty p%0d: got %0d want %0d", p, dutA.duty, seq[p]);
          end
        end
        exp = expQ.pop_front();
        checks++;
        if (busA.pwd_out !== exp) begin
          errors++; $display("FAIL ramp_pwd p%0d k%0d: got %b want %b", p, k, busA.pwd_out, exp);
        end
        if (busA.pwd_out === 1'b1) high++;
      end
      checks++;
      if (high != seq[p]) begin
        errors++; $display("FAIL ramp_high p%0d: got %0d want %0d", p, high, seq[p]);
      end
    end
  endtask

  task automatic test_saturation();
    int seq[8] = '{0, 4, 8, 10, 6, 2, 0, 4};
    rstB = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstB = 1'b1;
    for (int p = 0; p < 8; p++) begin
      int high = 0;
      pushPeriod(10, seq[p], 10);
      for (int k = 0; k < 10; k++) begin
        bit exp;
        @(posedge clk); @(negedge clk);
        if (k == 0) begin
          checks++;
          if (dutB.duty !== 8'(seq[p])) begin
            errors++; $display("FAIL sat_duty p%0d: got %0d want %0d", p, dutB.duty, seq[p]);
          end
        end
        exp = expQ.pop_front();
        checks++;
        if (busB.pwd_out !== exp) begin
          errors++; $display("FAIL sat_pwd p%0d k%0d: got %b want %b", p, k, busB.pwd_out, exp);
        end
        if (busB.pwd_out === 1'b1) high++;
      end
      checks++;
      if (high != seq[p]) begin
        errors++; $display("FAIL sat_high p%0d: got %0d want %0d", p, high, seq[p]);
      end
    end
  endtask

  // Continues instance B: periods 8..10 have duty 8, 10 (full scale), 6.
  task automatic test_full_scale();
    int seq[3] = '{8, 10, 6};
    for (int p = 0; p < 3; p++) begin
      int high = 0;
      pushPeriod(10, seq[p], 10);
      for (int k = 0; k < 10; k++) begin
        bit exp;
        @(posedge clk); @(negedge clk);
        exp = expQ.pop_front();
        checks++;
        if (busB.pwd_out !== exp) begin
          errors++; $display("FAIL full_pwd p%0d k%0d: got %b want %b", p, k, busB.pwd_out, exp);
        end
        if (busB.pwd_out === 1'b1) high++;
      end
      if (seq[p] == 10) begin
        checks++;
        if (high != 10) begin
          errors++; $display("FAIL full_scale: got %0d high cycles want 10", high);
        end
      end
    end
  endtask

  task automatic test_defaults_smoke();
    rstC = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstC = 1'b1;
    for (int p = 0; p < 5; p++) begin
      int high = 0;
      pushPeriod(200, p, 200);
      for (int k = 0; k < 200; k++) begin
        bit exp;
        @(posedge clk); @(negedge clk);
        exp = expQ.pop_front();
        if (busC.pwd_out !== exp) begin
          checks++; errors++;
          $display("FAIL smoke_pwd p%0d k%0d: got %b want %b", p, k, busC.pwd_out, exp);
        end
        if (busC.pwd_out === 1'b1) high++;
      end
      checks++;
      if (high != p) begin
        errors++; $display("FAIL smoke_high p%0d: got %0d want %0d", p, high, p);
      end
    end
  endtask

  // Reset at cnt = 100 of the duty-3 period, then the ramp restarts from 0.
  task automatic test_mid_reset();
    rstC = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstC = 1'b1;
    for (int p = 0; p < 4; p++) pushPeriod(200, p, (p == 3) ? 100 : 200);
    for (int j = 1; j <= 700; j++) begin
      bit exp;
      @(posedge clk); @(negedge clk);
      exp = expQ.pop_front();
      if (busC.pwd_out !== exp) begin
        checks++; errors++;
        $display("FAIL mid_pre_pwd j%0d: got %b want %b", j, busC.pwd_out, exp);
      end
    end
    checks++;
    if (dutC.uCore.cnt !== 8'd100 || dutC.duty !== 8'd3) begin
      errors++; $display("FAIL mid_pre_state: cnt=%0d duty=%0d want cnt=100 duty=3",
                         dutC.uCore.cnt, dutC.duty);
    end
    rstC = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (busC.pwd_out !== 1'b0) begin
      errors++; $display("FAIL mid_rst_pwd: got %b want 0", busC.pwd_out);
    end
    checks++;
    if (dutC.uCore.cnt !== 8'd0 || dutC.duty !== 8'd0 || dutC.dir !== UP) begin
      errors++; $display("FAIL mid_rst_state: cnt=%0d duty=%0d dir=%0d want 0 0 0",
                         dutC.uCore.cnt, dutC.duty, dutC.dir);
    end
    rstC = 1'b1;
    for (int p = 0; p < 2; p++) begin
      int high = 0;
      pushPeriod(200, p, 200);
      for (int k = 0; k < 200; k++) begin
        bit exp;
        @(posedge clk); @(negedge clk);
        exp = expQ.pop_front();
        if (busC.pwd_out !== exp) begin
          checks++; errors++;
          $display("FAIL mid_post_pwd p%0d k%0d: got %b want %b", p, k, busC.pwd_out, exp);
        end
        if (busC.pwd_out === 1'b1) high++;
      end
      checks++;
      if (high != p) begin
        errors++; $display("FAIL mid_post_high p%0d: got %0d want %0d", p, high, p);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_ramp();
    test_saturation();
    test_full_scale();
    test_defaults_smoke();
    test_mid_reset();
    checks++;
    if (expQ.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d entries left want 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
